// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, run/stop/lap FSM,
// 1 s prescaler and lap-freeze display register.
module stopwatch_ctrl #(
  parameter int DEBOUNCE = 1_000_000,
  parameter int PRESCALE = 100_000_000
) (
  input  logic        clk100MHz,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_lr,
  input  logic [15:0] time_bcd,
  output logic        pause,
  output logic        clr,
  output logic        tick1s,
  output logic [15:0] disp_bcd,
  output logic [1:0]  state
);

  localparam int DW = $clog2(DEBOUNCE + 2);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE - 1);
  localparam logic [DW-1:0] AMAX = DW'(DEBOUNCE + 1);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    LAP  = 2'd3
  } state_t;

  logic [1:0]         raw;
  logic [1:0]         s0;
  logic [1:0]         s1;
  logic [1:0]         db;
  logic [1:0]         db_d;
  logic [1:0]         arm;
  logic [1:0]         ev;
  logic [1:0][DW-1:0] dcnt;
  logic [1:0][DW-1:0] acnt;

  assign raw = {btn_lr, btn_ss};

  // A button is armed only after it has been seen released long enough
  // to cover synchroniser latency, so a button held through reset is ignored.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      s0   <= '0;
      s1   <= '0;
      db   <= '0;
      db_d <= '0;
      arm  <= '0;
      dcnt <= '0;
      acnt <= '0;
    end else begin
      s0   <= raw;
      s1   <= s0;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s1[i] == db[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DMAX) begin
          dcnt[i] <= '0;
          db[i]   <= s1[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
        if (s1[i] || db[i]) begin
          acnt[i] <= '0;
        end else if (acnt[i] == AMAX) begin
          arm[i] <= 1'b1;
        end else begin
          acnt[i] <= acnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev = db & ~db_d & arm;

  state_t        st;
  state_t        nxt;
  logic          clr_n;
  logic          run_c;
  logic          run_n;
  logic [PW-1:0] presc;

  assign state = st;

  always_comb begin
    nxt   = st;
    clr_n = 1'b0;
    case (st)
      IDLE: begin
        if (ev[0])      nxt = RUN;
        else if (ev[1]) clr_n = 1'b1;
      end
      RUN: begin
        if (ev[0])      nxt = STOP;
        else if (ev[1]) nxt = LAP;
      end
      LAP: begin
        if (ev[0])      nxt = STOP;
        else if (ev[1]) nxt = RUN;
      end
      STOP: begin
        if (ev[0]) begin
          nxt = RUN;
        end else if (ev[1]) begin
          nxt   = IDLE;
          clr_n = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign run_c = (st == RUN) || (st == LAP);
  assign run_n = (nxt == RUN) || (nxt == LAP);

  // Prescaler only advances while running on both sides of the edge,
  // so a tick can never coincide with pause.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      st       <= IDLE;
      pause    <= 1'b1;
      clr      <= 1'b0;
      tick1s   <= 1'b0;
      disp_bcd <= '0;
      presc    <= '0;
    end else begin
      st     <= nxt;
      pause  <= ~run_n;
      clr    <= clr_n;
      tick1s <= 1'b0;
      if (!((st == LAP) && (nxt == LAP))) begin
        disp_bcd <= time_bcd;
      end
      if (clr_n) begin
        presc <= '0;
      end else if (run_c && run_n) begin
        if (presc == PMAX) begin
          presc  <= '0;
          tick1s <= 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule
